// File: rtl/frog_ride_ctrl.sv
// frog_ride_ctrl: per-frame land/ride/sink/drown controller for the frog on lilypad rows.
// Inputs : Clk, Reset_n (async, active low), frame_tick, Frog_X/Frog_Y, Frog_Hop_Busy,
//          Row_Y/Row_Collision/Row_Remainder/Row_Direction (per row, packed), Respawn_Ack.
// Outputs: Ride_Step/Ride_Dir (1 px ride command), Riding, Sink_Active, Frog_Drown, Ride_Row.
// Option : FROG_RIDE_SINK_ANIM_EN keeps the frog in SINKING for SINK_FRAMES frames;
//          without it SINKING lasts one Clk and Sink_Active is tied low.
module frog_ride_ctrl #(
  parameter int ROWS        = 4,
  parameter int SCREEN_W    = 640,
  parameter int FROG_W      = 32,
  parameter int SINK_FRAMES = 30
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_tick,
  input  logic [10:0]       Frog_X,
  input  logic [10:0]       Frog_Y,
  input  logic              Frog_Hop_Busy,
  input  logic [ROWS*11-1:0] Row_Y,
  input  logic [ROWS-1:0]   Row_Collision,
  input  logic [ROWS*6-1:0] Row_Remainder,
  input  logic [ROWS-1:0]   Row_Direction,
  input  logic              Respawn_Ack,
  output logic              Ride_Step,
  output logic              Ride_Dir,
  output logic              Riding,
  output logic              Sink_Active,
  output logic              Frog_Drown,
  output logic [2:0]        Ride_Row
);
  typedef enum logic [1:0] {LAND, RIDING, SINKING, DROWNED} state_t;
  if (ROWS < 1 || ROWS > 8 || SINK_FRAMES < 1 || SINK_FRAMES > 63) begin : g_bad_param
    $error("frog_ride_ctrl: parameter out of range");
  end
  state_t      state_q, state_d;
  logic [2:0]  ride_row_q, ride_row_d, match_r;
  logic        ride_step_q, ride_step_d, ride_dir_q, ride_dir_d;
  logic        match_v, match_coll, match_dir, at_edge;
  logic [5:0]  match_rem;
  logic [11:0] x_end;
`ifdef FROG_RIDE_SINK_ANIM_EN
  logic [5:0]  sink_q, sink_d;
`endif
  // Lowest-index row whose y equals the frog's y; its per-row inputs are captured alongside.
  always_comb begin
    match_v    = 1'b0;
    match_r    = '0;
    match_coll = 1'b0;
    match_dir  = 1'b0;
    match_rem  = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (Frog_Y == Row_Y[i*11 +: 11]) begin
        match_v    = 1'b1;
        match_r    = 3'(i);
        match_coll = Row_Collision[i];
        match_dir  = Row_Direction[i];
        match_rem  = Row_Remainder[i*6 +: 6];
      end
    end
  end
  // 12-bit sum so a frog near x=2047 cannot wrap past the right edge.
  assign x_end   = {1'b0, Frog_X} + 12'(FROG_W);
  assign at_edge = match_dir ? (x_end >= 12'(SCREEN_W)) : (Frog_X == '0);
  // While riding, the frog stays at the matched row's y, so the matched row is the ridden row;
  // re-matching each frame also picks up a new row after a hop.
  always_comb begin
    state_d     = state_q;
    ride_row_d  = ride_row_q;
    ride_step_d = 1'b0;
    ride_dir_d  = ride_dir_q;
`ifdef FROG_RIDE_SINK_ANIM_EN
    sink_d      = sink_q;
`endif
    case (state_q)
      LAND: if (frame_tick && !Frog_Hop_Busy && match_v) begin
        state_d    = match_coll ? RIDING : SINKING;
        ride_row_d = match_coll ? match_r : ride_row_q;
      end
      RIDING: if (frame_tick && !Frog_Hop_Busy) begin
        if (!match_v) state_d = LAND;
        else if (!match_coll) state_d = SINKING;
        else begin
          ride_row_d = match_r;
          if (match_rem == '0) begin
            if (at_edge) state_d = SINKING;
            else begin
              ride_step_d = 1'b1;
              ride_dir_d  = match_dir;
            end
          end
        end
      end
`ifdef FROG_RIDE_SINK_ANIM_EN
      SINKING: if (frame_tick) begin
        if (sink_q == '0) state_d = DROWNED;
        else sink_d = sink_q - 6'd1;
      end
`else
      SINKING: state_d = DROWNED;
`endif
      DROWNED: if (Respawn_Ack) state_d = LAND;
      default: state_d = LAND;
    endcase
`ifdef FROG_RIDE_SINK_ANIM_EN
    if (state_d == SINKING && state_q != SINKING) sink_d = 6'(SINK_FRAMES - 1);
`endif
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= LAND;
      ride_row_q  <= '0;
      ride_step_q <= 1'b0;
      ride_dir_q  <= 1'b0;
`ifdef FROG_RIDE_SINK_ANIM_EN
      sink_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ride_row_q  <= ride_row_d;
      ride_step_q <= ride_step_d;
      ride_dir_q  <= ride_dir_d;
`ifdef FROG_RIDE_SINK_ANIM_EN
      sink_q      <= sink_d;
`endif
    end
  end
  assign Ride_Step  = ride_step_q;
  assign Ride_Dir   = ride_dir_q;
  assign Ride_Row   = ride_row_q;
  assign Riding     = state_q == RIDING;
  assign Frog_Drown = state_q == DROWNED;
`ifdef FROG_RIDE_SINK_ANIM_EN
  assign Sink_Active = state_q == SINKING;
`else
  assign Sink_Active = 1'b0;
`endif
endmodule
